// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encodings and constants for the MEM-stage access unit
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int          CNT_W           = 8;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack data-memory bus between the access unit and memory
// Signals:
//   req   : memory request, held until ack
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : write data
//   ack   : single-cycle completion from memory
//   rdata : read data, valid with ack
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - saturating watchdog counter for outstanding memory accesses
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : zero the counter (wins over enable_i)
//   enable_i     : count one cycle
//   expired_o    : counter has reached TIMEOUT-1
module mem_timeout_cnt
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter holds k during the (k+1)-th WAIT cycle, so this fires on WAIT cycle TIMEOUT.
    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access unit with stall and watchdog
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   MemRead_i, MemWrite_i : load/store request from EX/MEM
//   addr_i, wdata_i       : byte address and store data from EX/MEM
//   stall_o               : freezes EX/MEM and upstream while an access is pending
//   rdata_o               : load data to MEM/WB, valid in DONE, held until next load
//   err_o                 : one-cycle pulse on misaligned access or timeout
//   mem                   : req/ack data-memory bus (master side)
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       MemRead_i,
    input  logic                       MemWrite_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                wdata_i,
    output logic                       stall_o,
    output logic [31:0]                rdata_o,
    output logic                       err_o,
    mem_access_unit_if.master          mem
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic access, misaligned;
    logic cnt_clr, cnt_en, cnt_expired;

    assign access     = MemRead_i | MemWrite_i;
    assign misaligned = access & (addr_i[1:0] != 2'b00);

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (cnt_clr),
        .enable_i  (cnt_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (access) begin
                    // Write wins when both controls are set.
                    req_d   = 1'b1;
                    we_d    = MemWrite_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = wdata_i;
                    cnt_clr = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem.rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            // DONE is the unstalled cycle in which the pipeline advances; the
            // controls still on the inputs belong to the finished access.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign stall_o   = ((state_q == S_IDLE) & access & ~misaligned) | (state_q == S_WAIT);
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

endmodule
